// File: rtl/oscillator_mc_if.sv
`default_nettype none
// ============================================================================
//  Module      : oscillator_mc_if
//  Description : Control, load and sample-output bundle of the multi-channel
//                recursive sinusoid generator.
//                  master : sweep strobe, enable mask, channel load,
//                           overrun clear; receives tagged samples and status.
//                  slave  : the generator itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface oscillator_mc_if #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4
);
   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic                tick;
   logic [CHANNELS-1:0] ch_en;
   logic                load_en;
   logic [CH_W-1:0]     load_ch;
   logic [WIDTH-1:0]    load_init1;
   logic [WIDTH-1:0]    load_coef;
   logic                load_ready;
   logic                busy;
   logic                out_valid;
   logic [CH_W-1:0]     out_ch;
   logic [WIDTH-1:0]    out_data;
   logic                out_sat;
   logic                overrun;
   logic                overrun_clr;

   modport master (
      output tick, ch_en, load_en, load_ch, load_init1, load_coef, overrun_clr,
      input  load_ready, busy, out_valid, out_ch, out_data, out_sat, overrun
   );

   modport slave (
      input  tick, ch_en, load_en, load_ch, load_init1, load_coef, overrun_clr,
      output load_ready, busy, out_valid, out_ch, out_data, out_sat, overrun
   );
endinterface
`default_nettype wire

// File: rtl/oscillator_mc.sv
`default_nettype none
// ============================================================================
//  Module      : oscillator_mc
//  Description : Time-multiplexed multi-channel recursive sinusoid generator.
//                Each channel evaluates y[n] = coef*y[n-1] - y[n-2] with coef
//                in Q(WIDTH-FRAC).FRAC. One shared multiplier, two-stage
//                pipeline, saturating result, per-channel load and enable.
//  Ports       : Fg_CLK  - clock, rising edge
//                RESET   - asynchronous reset, active-high
//                bus     - oscillator_mc_if.slave (tick, ch_en, load_*,
//                          overrun_clr in; load_ready, busy, out_*, overrun out)
//  Revision    : 1.0 - initial release
// ============================================================================
module oscillator_mc #(
   parameter int WIDTH    = 32,
   parameter int FRAC     = 29,
   parameter int CHANNELS = 4
) (
   input  wire logic       Fg_CLK,
   input  wire logic       RESET,
   oscillator_mc_if.slave  bus
);
   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int PW   = 2 * WIDTH;
   localparam int DW   = WIDTH + FRAC + 1;
   localparam logic [CH_W-1:0] c_LAST_SLOT = CH_W'(CHANNELS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,   // one slot enters stage 1 per cycle
      ST_DRAIN = 2'd2    // last slot finishes stage 2
   } state_t;

   state_t                  r_state;
   logic [CH_W-1:0]         r_slot;
   logic                    r_busy;
   logic                    r_ovr;

   logic signed [WIDTH-1:0] r_y1   [CHANNELS];
   logic signed [WIDTH-1:0] r_y2   [CHANNELS];
   logic signed [WIDTH-1:0] r_coef [CHANNELS];

   // Stage 1 registers
   logic                    r_s1_vld;
   logic                    r_s1_en;
   logic [CH_W-1:0]         r_s1_ch;
   logic signed [PW-1:0]    r_s1_p;
   logic signed [WIDTH-1:0] r_s1_y1;
   logic signed [WIDTH-1:0] r_s1_y2;

   // Registered outputs
   logic                    r_out_valid;
   logic [CH_W-1:0]         r_out_ch;
   logic signed [WIDTH-1:0] r_out_data;
   logic                    r_out_sat;

   // ---------------- Stage 1: shared multiplier ----------------
   logic signed [PW-1:0]    w_coef_x;
   logic signed [PW-1:0]    w_y1_x;
   logic signed [PW-1:0]    w_p;

   assign w_coef_x = PW'(r_coef[r_slot]);
   assign w_y1_x   = PW'(r_y1[r_slot]);
   assign w_p      = w_coef_x * w_y1_x;

   // ---------------- Stage 2: scale, subtract, saturate ----------------
   logic signed [DW-1:0]    w_q;
   logic signed [DW-1:0]    w_y2_x;
   logic signed [DW-1:0]    w_d;
   logic [DW-WIDTH:0]       w_hi;
   logic                    w_ovf;
   logic signed [WIDTH-1:0] w_y_new;

   // Arithmetic shift floors; the quotient always fits in DW bits.
   assign w_q    = DW'(r_s1_p >>> FRAC);
   assign w_y2_x = DW'(r_s1_y2);
   assign w_d    = w_q - w_y2_x;

   // In range exactly when every bit from the WIDTH-bit sign position up
   // is a copy of the sign.
   assign w_hi    = w_d[DW-1:WIDTH-1];
   assign w_ovf   = ~((&w_hi) | ~(|w_hi));
   assign w_y_new = !w_ovf        ? w_d[WIDTH-1:0] :
                    w_d[DW-1]     ? {1'b1, {(WIDTH-1){1'b0}}} :
                                    {1'b0, {(WIDTH-1){1'b1}}};

   logic w_ld_ok;
   assign w_ld_ok = bus.load_en && !r_busy && (32'(bus.load_ch) < 32'(CHANNELS));

   always_ff @(posedge Fg_CLK or posedge RESET) begin
      if (RESET) begin
         r_state     <= ST_IDLE;
         r_slot      <= '0;
         r_busy      <= 1'b0;
         r_ovr       <= 1'b0;
         r_s1_vld    <= 1'b0;
         r_s1_en     <= 1'b0;
         r_s1_ch     <= '0;
         r_s1_p      <= '0;
         r_s1_y1     <= '0;
         r_s1_y2     <= '0;
         r_out_valid <= 1'b0;
         r_out_ch    <= '0;
         r_out_data  <= '0;
         r_out_sat   <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin
            r_y1[i]   <= '0;
            r_y2[i]   <= '0;
            r_coef[i] <= '0;
         end
      end else begin
         // Set has priority over clear.
         if (bus.tick && r_busy)
            r_ovr <= 1'b1;
         else if (bus.overrun_clr)
            r_ovr <= 1'b0;

         r_s1_vld    <= 1'b0;
         r_out_valid <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (bus.tick) begin
                  r_state <= ST_ISSUE;
                  r_slot  <= '0;
                  r_busy  <= 1'b1;
               end
            end
            ST_ISSUE: begin
               // Disabled slots still occupy the pipeline so sweep timing
               // does not depend on the mask.
               r_s1_vld <= 1'b1;
               r_s1_en  <= bus.ch_en[r_slot];
               r_s1_ch  <= r_slot;
               r_s1_p   <= w_p;
               r_s1_y1  <= r_y1[r_slot];
               r_s1_y2  <= r_y2[r_slot];
               if (r_slot == c_LAST_SLOT)
                  r_state <= ST_DRAIN;
               else
                  r_slot <= r_slot + CH_W'(1);
            end
            ST_DRAIN: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase

         // Writeback of channel i coincides with the stage-1 read of i+1,
         // so the two never touch the same channel.
         if (r_s1_vld && r_s1_en) begin
            r_y2[r_s1_ch] <= r_s1_y1;
            r_y1[r_s1_ch] <= w_y_new;
            r_out_valid   <= 1'b1;
            r_out_ch      <= r_s1_ch;
            r_out_data    <= w_y_new;
            r_out_sat     <= w_ovf;
         end

         // Loads are only accepted while idle, so they never collide with
         // a writeback.
         if (w_ld_ok) begin
            r_y1[bus.load_ch]   <= bus.load_init1;
            r_y2[bus.load_ch]   <= '0;
            r_coef[bus.load_ch] <= bus.load_coef;
         end
      end
   end

   assign bus.load_ready = ~r_busy;
   assign bus.busy       = r_busy;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_ch     = r_out_ch;
   assign bus.out_data   = r_out_data;
   assign bus.out_sat    = r_out_sat;
   assign bus.overrun    = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_oscillator_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_oscillator_mc
//  Description : Self-checking bench for oscillator_mc. A timeline model
//                computes each sample from the recurrence with plain integer
//                arithmetic and schedules it for its output edge; directed
//                sequences pin the model with hand-computed literals.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_oscillator_mc;
   localparam int WIDTH    = 32;
   localparam int FRAC     = 29;
   localparam int CHANNELS = 4;
   localparam int A        = 32'h1000_0000;
   localparam int ONE      = 1 << FRAC;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   oscillator_mc_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

   oscillator_mc #(.WIDTH(WIDTH), .FRAC(FRAC), .CHANNELS(CHANNELS)) dut (
      .Fg_CLK (clk),
      .RESET  (rst),
      .bus    (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                    name, act, act, exp, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int unsigned cyc;
      int          ch;
      int          data;
      bit          sat;
   } ev_t;

   ev_t         evq[$];
   int          m_y1   [CHANNELS];
   int          m_y2   [CHANNELS];
   int          m_coef [CHANNELS];
   bit          m_busy = 1'b0;
   bit          m_ovr  = 1'b0;
   int unsigned m_k    = 0;
   int unsigned cyc    = 0;

   always @(posedge clk or posedge rst) begin : p_model
      int     s;
      longint p, d;
      bit     bb, st;
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            m_y1[i] = 0; m_y2[i] = 0; m_coef[i] = 0;
         end
         m_busy = 1'b0;
         m_ovr  = 1'b0;
         evq.delete();
      end else begin
         cyc++;
         bb = m_busy;
         if (bus.tick && bb) m_ovr = 1'b1;
         else if (bus.overrun_clr) m_ovr = 1'b0;
         if (bb) begin
            // Slot s is sampled one edge after the tick; its sample shows
            // one edge after that.
            s = int'(cyc - m_k) - 1;
            if (s >= 0 && s < CHANNELS && bus.ch_en[s]) begin
               p  = longint'(m_coef[s]) * longint'(m_y1[s]);
               d  = (p >>> FRAC) - longint'(m_y2[s]);
               st = 1'b0;
               if (d > 64'sd2147483647)  begin d = 64'sd2147483647;  st = 1'b1; end
               if (d < -64'sd2147483648) begin d = -64'sd2147483648; st = 1'b1; end
               m_y2[s] = m_y1[s];
               m_y1[s] = int'(d);
               evq.push_back('{cyc + 1, s, int'(d), st});
            end
            if (cyc == m_k + CHANNELS + 1) m_busy = 1'b0;
         end
         if (bus.load_en && !bb && int'(bus.load_ch) < CHANNELS) begin
            m_y1[bus.load_ch]   = int'(bus.load_init1);
            m_y2[bus.load_ch]   = 0;
            m_coef[bus.load_ch] = int'(bus.load_coef);
         end
         if (bus.tick && !bb) begin
            m_busy = 1'b1;
            m_k    = cyc;
         end
      end
   end

   // ---------------- compare process ----------------
   int          obs_data [CHANNELS];
   bit          obs_sat  [CHANNELS];
   int unsigned obs_edge [CHANNELS];
   int          obs_cnt  [CHANNELS];

   always @(negedge clk) begin : p_cmp
      bit  ev_v;
      ev_t e;
      if (!rst) begin
         chk("busy", bus.busy, m_busy);
         chk("load_ready", bus.load_ready, !m_busy);
         chk("overrun", bus.overrun, m_ovr);
         ev_v = (evq.size() > 0) && (evq[0].cyc == cyc);
         chk("out_valid", bus.out_valid, ev_v);
         if (ev_v) begin
            e = evq.pop_front();
            chk("out_ch", bus.out_ch, e.ch);
            chk("out_data", longint'($signed(bus.out_data)), longint'(e.data));
            chk("out_sat", bus.out_sat, e.sat);
         end
         if (bus.out_valid) begin
            obs_data[bus.out_ch] = int'($signed(bus.out_data));
            obs_sat[bus.out_ch]  = bus.out_sat;
            obs_edge[bus.out_ch] = cyc;
            obs_cnt[bus.out_ch]++;
         end
      end
   end

   // ---------------- stimulus ----------------
   int unsigned sw_k, sw_fall;
   int qr [5]   = '{0, -A, 0, A, 0};
   int p6 [7]   = '{A, 0, -A, -A, 0, A, A};
   int sv [3]   = '{32'h4000_0000, 32'h6000_0000, 32'h7FFF_FFFF};
   bit sf [3]   = '{1'b0, 1'b0, 1'b1};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_obs();
      for (int i = 0; i < CHANNELS; i++) obs_cnt[i] = 0;
   endtask

   task automatic load(input int ch, input int init1, input int coef);
      bus.load_en    = 1'b1;
      bus.load_ch    = 2'(ch);
      bus.load_init1 = init1;
      bus.load_coef  = coef;
      step();
      bus.load_en    = 1'b0;
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         step();
         if (!bus.busy) begin
            done    = 1'b1;
            sw_fall = cyc;
         end
      end
      if (!done) chk("sweep_timeout", 0, 1);
      step();   // let the final sample be observed
   endtask

   task automatic sweep(input logic [CHANNELS-1:0] en);
      bus.ch_en = en;
      bus.tick  = 1'b1;
      step();
      sw_k      = cyc;
      bus.tick  = 1'b0;
      wait_idle();
   endtask

   initial begin
      bus.tick = 1'b0; bus.ch_en = '0; bus.load_en = 1'b0; bus.load_ch = '0;
      bus.load_init1 = '0; bus.load_coef = '0; bus.overrun_clr = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         obs_data[i] = 0; obs_sat[i] = 0; obs_edge[i] = 0; obs_cnt[i] = 0;
      end

      // Reset values
      repeat (3) @(posedge clk);
      #2;
      chk("rst_busy", bus.busy, 0);
      chk("rst_load_ready", bus.load_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_overrun", bus.overrun, 0);
      step();
      rst = 1'b0;
      step();

      // Reset in the middle of a sweep
      for (int i = 0; i < CHANNELS; i++) load(i, A, ONE);
      bus.ch_en = 4'b1111;
      bus.tick  = 1'b1;
      step();
      bus.tick  = 1'b0;
      step();
      step();              // channel 0 sample is on the outputs now
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", bus.out_valid, 0);
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_load_ready", bus.load_ready, 1);
      chk("midrst_out_data", bus.out_data, 0);
      step();
      step();
      rst = 1'b0;
      step();
      clr_obs();
      sweep(4'b1111);
      for (int i = 0; i < CHANNELS; i++) begin
         chk("zero_after_rst_cnt", obs_cnt[i], 1);
         chk("zero_after_rst_data", obs_data[i], 0);
      end

      // Quarter-rate, period-6 and saturation sequences side by side
      load(0, A, 0);
      load(1, A, ONE);
      load(2, 32'h2000_0000, 1 << (FRAC + 1));
      for (int t = 0; t < 7; t++) begin
         sweep(4'b0111);
         if (t < 5) chk("quarter_rate", obs_data[0], qr[t]);
         chk("period6", obs_data[1], p6[t]);
         if (t < 3) begin
            chk("sat_data", obs_data[2], sv[t]);
            chk("sat_flag", obs_sat[2], sf[t]);
         end
      end

      // Multichannel timing with a masked channel
      load(0, A, 0);
      load(1, A, ONE);
      load(2, A, ONE);
      load(3, 32'h0800_0000, 1 << (FRAC + 1));
      clr_obs();
      sweep(4'b1011);
      chk("mc_edge_ch0", obs_edge[0], sw_k + 2);
      chk("mc_edge_ch1", obs_edge[1], sw_k + 3);
      chk("mc_edge_ch3", obs_edge[3], sw_k + 5);
      chk("mc_ch2_silent", obs_cnt[2], 0);
      chk("mc_busy_fall", sw_fall, sw_k + 5);
      chk("mc_ch0_data", obs_data[0], 0);
      chk("mc_ch1_data", obs_data[1], A);
      chk("mc_ch3_data", obs_data[3], 32'h1000_0000);
      sweep(4'b0100);
      chk("mc_ch2_untouched", obs_data[2], A);

      // Overrun and load gating
      load(0, A, 0);
      clr_obs();
      bus.ch_en = 4'b0001;
      bus.tick  = 1'b1;
      step();
      bus.tick  = 1'b0;
      step();
      bus.tick       = 1'b1;   // tick two edges after the accepted one
      bus.load_en    = 1'b1;   // load while busy
      bus.load_ch    = 2'd0;
      bus.load_init1 = 32'h0100_0000;
      bus.load_coef  = ONE;
      step();
      bus.tick    = 1'b0;
      bus.load_en = 1'b0;
      wait_idle();
      chk("ovr_set", bus.overrun, 1);
      chk("ovr_one_sweep", obs_cnt[0], 1);
      sweep(4'b0001);
      chk("load_while_busy_ignored", obs_data[0], -A);
      bus.overrun_clr = 1'b1;
      step();
      bus.overrun_clr = 1'b0;
      chk("ovr_cleared", bus.overrun, 0);
      bus.tick = 1'b1;
      step();
      bus.overrun_clr = 1'b1;  // clear and overrunning tick together
      step();
      bus.tick        = 1'b0;
      bus.overrun_clr = 1'b0;
      chk("ovr_set_wins", bus.overrun, 1);
      wait_idle();

      chk("model_queue_drained", evq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end
endmodule
`default_nettype wire
